// File: rtl/photo_sensor_pkg.sv
// Shared definitions for the photo-interrupter sensor blocks.
// The LED mode encoding is common to every channel and to the register map.
package photo_sensor_pkg;

    typedef enum logic [1:0] {
        MODE_FOLLOW  = 2'd0,
        MODE_TOGGLE  = 2'd1,
        MODE_STRETCH = 2'd2,
        MODE_OFF     = 2'd3
    } led_mode_e;

endpackage

// File: rtl/photo_interrupter_channel.sv
// One sensor channel: synchroniser, debounce, rise detect, saturating event
// counter, toggle flop, retriggerable stretch timer and registered LED select.
module photo_interrupter_channel
    import photo_sensor_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16,
    parameter int STRETCH_CYCLES  = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor,
    input  logic [1:0]       mode,
    input  logic             clr_cnt,
    output logic             state,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             led
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STRETCH_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LOAD = ST_W'(STRETCH_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   state_q, state_d;
    logic                   rise_q, rise_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   toggle_q, toggle_d;
    logic [ST_W-1:0]        stretch_q, stretch_d;
    logic                   led_q, led_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sync_d     = {sync_q[SYNC_STAGES-2:0], sensor};
        db_cnt_d   = '0;
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        stretch_d  = stretch_q;
        led_d      = 1'b0;

        // The new level is accepted on the cycle that completes the persistence window.
        if (sync_out != state_q) begin
            if (db_cnt_q == DB_LAST) state_d = sync_out;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end

        // Registered so the strobe coincides with the first cycle state reads 1.
        rise_d = state_d & ~state_q;

        if (clr_cnt) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (rise_q) begin
            if (&count_q) overflow_d = 1'b1;
            else          count_d    = count_q + 1'b1;
        end

        toggle_d = toggle_q ^ rise_q;

        if (rise_q)                stretch_d = ST_LOAD;
        else if (stretch_q != '0)  stretch_d = stretch_q - 1'b1;

        case (led_mode_e'(mode))
            MODE_FOLLOW:  led_d = state_q;
            MODE_TOGGLE:  led_d = toggle_q;
            MODE_STRETCH: led_d = (stretch_q != '0);
            default:      led_d = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            state_q    <= 1'b0;
            rise_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            toggle_q   <= 1'b0;
            stretch_q  <= '0;
            led_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            rise_q     <= rise_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            toggle_q   <= toggle_d;
            stretch_q  <= stretch_d;
            led_q      <= led_d;
        end
    end

    assign state      = state_q;
    assign rise_pulse = rise_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign led        = led_q;

endmodule

// File: rtl/photo_interrupter_array.sv
// N_CH independent photo-interrupter channels sharing clock, reset, LED mode
// and counter clear; per-channel counts are packed into one flat bus.
module photo_interrupter_array
    import photo_sensor_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16,
    parameter int STRETCH_CYCLES  = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       sensor,
    input  logic [1:0]            mode,
    input  logic                  clr_cnt,
    output logic [N_CH-1:0]       state,
    output logic [N_CH-1:0]       rise_pulse,
    output logic [N_CH*CNT_W-1:0] count,
    output logic [N_CH-1:0]       overflow,
    output logic [N_CH-1:0]       led
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        photo_interrupter_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .STRETCH_CYCLES  (STRETCH_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .sensor     (sensor[i]),
            .mode       (mode),
            .clr_cnt    (clr_cnt),
            .state      (state[i]),
            .rise_pulse (rise_pulse[i]),
            .count      (count[i*CNT_W +: CNT_W]),
            .overflow   (overflow[i]),
            .led        (led[i])
        );
    end

endmodule
